// File: rtl/pwm_peripheral_if.sv
// rtl/pwm_peripheral_if.sv - register-side inputs and pin-side outputs of the PWM output stage
interface pwm_peripheral_if;
  logic [7:0]  en_reg_out_7_0;
  logic [7:0]  en_reg_out_15_8;
  logic [7:0]  en_reg_pwm_7_0;
  logic [7:0]  en_reg_pwm_15_8;
  logic [7:0]  pwm_duty_cycle;
  logic [15:0] out;
  logic        period_start;

  modport master (
    output en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle,
    input  out, period_start
  );

  modport slave (
    input  en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle,
    output out, period_start
  );
endinterface

// File: rtl/pwm_peripheral.sv
// rtl/pwm_peripheral.sv - 16-pin output stage: each pin low, high, or shared PWM waveform
// Optional PWM_SHADOW_EN: duty is latched only at the 255->0 wrap of the PWM counter.
module pwm_peripheral #(
  parameter int CLK_DIV  = 3000,
  parameter int PWM_BITS = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  pwm_peripheral_if.slave bus
);
  localparam int PS_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PS_W-1:0]     PS_LAST = PS_W'(CLK_DIV - 1);
  localparam logic [PWM_BITS-1:0] CNT_MAX = '1;

  logic [PS_W-1:0]     prescaler_q, prescaler_d;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic                period_start_q, period_start_d;
  logic [15:0]         out_q, out_d;
  logic [15:0]         en_out, en_pwm;
  logic [PWM_BITS-1:0] duty_active;
  logic                tick, wrap, pwm_sig;

  assign en_out = {bus.en_reg_out_15_8, bus.en_reg_out_7_0};
  assign en_pwm = {bus.en_reg_pwm_15_8, bus.en_reg_pwm_7_0};

  assign tick = (prescaler_q == PS_LAST);
  assign wrap = tick && (pwm_cnt_q == CNT_MAX);

`ifdef PWM_SHADOW_EN
  logic [PWM_BITS-1:0] duty_active_q, duty_active_d;

  always_comb begin
    duty_active_d = duty_active_q;
    if (wrap) duty_active_d = bus.pwm_duty_cycle;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) duty_active_q <= '0;
    else        duty_active_q <= duty_active_d;
  end

  assign duty_active = duty_active_q;
`else
  assign duty_active = bus.pwm_duty_cycle;
`endif

  always_comb begin
    prescaler_d    = tick ? '0 : prescaler_q + 1'b1;
    pwm_cnt_d      = tick ? pwm_cnt_q + 1'b1 : pwm_cnt_q;
    period_start_d = wrap;

    // Full scale is forced high so 0xFF does not drop for the cnt==255 tick.
    if (duty_active == '0)          pwm_sig = 1'b0;
    else if (duty_active == CNT_MAX) pwm_sig = 1'b1;
    else                             pwm_sig = (pwm_cnt_q < duty_active);

    out_d = en_out & (~en_pwm | {16{pwm_sig}});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescaler_q    <= '0;
      pwm_cnt_q      <= '0;
      period_start_q <= 1'b0;
      out_q          <= '0;
    end else begin
      prescaler_q    <= prescaler_d;
      pwm_cnt_q      <= pwm_cnt_d;
      period_start_q <= period_start_d;
      out_q          <= out_d;
    end
  end

  assign bus.out          = out_q;
  assign bus.period_start = period_start_q;
endmodule

// File: doc/pwm_peripheral.md
Name: pwm_peripheral

Overview:
- Consumes the five control registers produced by the SPI register block: output enables, PWM-mode enables and the 8-bit duty cycle.
- Drives 16 output pins. Each pin is forced low, held high, or driven by a shared PWM waveform.
- Sits directly downstream of the SPI register block; its outputs go to the top-level output pins.

Parameters:
- CLK_DIV, 3000, system clocks per PWM tick (must be >= 1). At 10 MHz this gives about 13 Hz per 256-tick period.
- PWM_BITS, 8, PWM counter and duty width. Fixed at 8 for this tapeout.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- en_reg_out_7_0  input  8  output enable, pins 7..0
- en_reg_out_15_8  input  8  output enable, pins 15..8
- en_reg_pwm_7_0  input  8  PWM-mode enable, pins 7..0
- en_reg_pwm_15_8  input  8  PWM-mode enable, pins 15..8
- pwm_duty_cycle  input  8  requested duty, 0x00..0xFF
- out  output  16  pin drive; bits 15..8 map to the *_15_8 registers
- period_start  output  1  one-clk pulse on the first clk of each PWM period

Behaviour:
- Reset (async assert, sync release):
  - out=0, period_start=0, prescaler=0, pwm_cnt=0, duty_active=0.
- Prescaler:
  - Counts 0..CLK_DIV-1 and wraps.
  - tick=1 on the clk where prescaler==CLK_DIV-1.
  - CLK_DIV=1: tick every clk.
- PWM counter:
  - pwm_cnt (8-bit) increments on tick, wrapping 255->0.
  - Period = 256*CLK_DIV clks.
- period_start:
  - Registered.
  - Asserted for exactly one clk, on the clk after pwm_cnt wraps to 0.
  - Not asserted out of reset until the first wrap.
- pwm_sig (combinational from pwm_cnt and duty_active):
  - duty_active==0x00: always 0.
  - duty_active==0xFF: always 1 (100% special case, no 1-tick glitch).
  - Otherwise: 1 when pwm_cnt < duty_active, giving a high time of duty_active ticks per 256.
- Pin select, per bit i, with en_out/en_pwm the concatenated 16-bit enables:
  - en_out[i]==0 -> 0 (takes priority over en_pwm).
  - en_out[i]==1, en_pwm[i]==0 -> 1.
  - Both enables set -> pwm_sig.
- out is registered: a change in enables or pwm_cnt appears on out one clk later.
- Enable changes take effect immediately (next clk); they are not period-aligned.
- All inputs are synchronous to clk, being registered outputs of the SPI block; no synchronizers here.
- Mid-period reset: everything returns to reset values immediately; the waveform restarts at pwm_cnt=0 after release.

Optional Feature:
- Macro: PWM_SHADOW_EN
- Defined:
  - duty_active is a shadow register loaded from pwm_duty_cycle only on the tick that wraps pwm_cnt 255->0.
  - Duty changes therefore apply at the next period boundary only; no mid-period glitch.
  - Two writes within one period: only the value present at the wrap is used.
- Undefined:
  - duty_active is pwm_duty_cycle directly (no register).
  - A duty change affects the current period on the next clk.

Test Plan (CLK_DIV=4 unless stated):
- Reset held, all inputs 0xFF -> out=0x0000 and period_start=0 throughout. Release -> out all high per the 0xFF duty rule one clk after the first edge.
- en_out=0xFFFF, en_pwm=0x0000 -> out=0xFFFF after 1 clk. en_out=0x00F0 -> out=0x00F0.
- en_out=0xFFFF, en_pwm=0x0001, duty=0x40 -> out[0] high 64 ticks (256 clks) per 1024-clk period; other bits constant 1; period_start pulses every 1024 clks.
- Duty 0x00 -> out[0] constantly 0. Duty 0xFF -> constantly 1 over 3 full periods. Duty 0x01 -> exactly 4 clks high per period.
- PWM_SHADOW_EN defined: duty changes 0x40->0xC0 mid-period -> current period keeps 64-tick high; next period is 192 ticks. Undefined: change visible within 1 clk.
- CLK_DIV=1: duty=0x80 -> 128 clks high of 256. Reset asserted mid-high -> out=0 immediately; after release pwm_cnt restarts at 0.
